// File: rtl/wb_trace_serializer.sv
// Dual-issue writeback trace serializer.
//
// This block accepts up to two register-writeback commits per cycle. Lane 0 is
// older than lane 1. Commits are buffered in a FIFO and emitted strictly in
// program order, one per cycle, on the debug_wb_* trace port.
//
// Ports:
//   clk, resetn            core clock; asynchronous active-low reset
//   wb{0,1}_en/rd/wdata/pc commit lanes (lane 0 older)
//   out_ready              trace sink accepts the head entry
//   debug_wb_pc/rf_wen/rf_wnum/rf_wdata
//                          head entry, all zero while the FIFO is empty
//   stall_req              pipeline must not present commits (fewer than 2 free slots)
//   overflow               sticky: commits were presented while stalled and dropped
//   commit_cnt             number of entries popped (wraps)
//
// Optional feature: define WB_TRACE_SKIP_R0_EN to drop writes to $0. Such writes
// are not buffered and do not consume a slot.
module wb_trace_serializer #(
  parameter int unsigned DEPTH = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb0_en,
  input  logic [4:0]  wb0_rd,
  input  logic [31:0] wb0_wdata,
  input  logic [31:0] wb0_pc,
  input  logic        wb1_en,
  input  logic [4:0]  wb1_rd,
  input  logic [31:0] wb1_wdata,
  input  logic [31:0] wb1_pc,
  input  logic        out_ready,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata,
  output logic        stall_req,
  output logic        overflow,
  output logic [31:0] commit_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  // Fewer than two free slots means count >= DEPTH-1.
  localparam logic [AW:0] StallLevel = (AW + 1)'(DEPTH - 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] wdata;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [31:0]   commit_cnt_q, commit_cnt_d;

  logic          lane0_ok, lane1_ok;
  logic          do_push0, do_push1, pop, out_valid;
  logic [AW:0]   n_push;
  logic [AW-1:0] wr1_idx;
  entry_t        head_entry;

`ifdef WB_TRACE_SKIP_R0_EN
  assign lane0_ok = wb0_en && (wb0_rd != 5'd0);
  assign lane1_ok = wb1_en && (wb1_rd != 5'd0);
`else
  assign lane0_ok = wb0_en;
  assign lane1_ok = wb1_en;
`endif

  assign out_valid  = (count_q != '0);
  assign stall_req  = (count_q >= StallLevel);
  assign head_entry = mem_q[head_q];

  always_comb begin
    do_push0     = !stall_req && lane0_ok;
    do_push1     = !stall_req && lane1_ok;
    pop          = out_valid && out_ready;
    n_push       = {{AW{1'b0}}, do_push0} + {{AW{1'b0}}, do_push1};
    // Lane 1 lands behind lane 0 only when lane 0 actually took a slot.
    wr1_idx      = tail_q + {{(AW - 1){1'b0}}, do_push0};
    tail_d       = tail_q + n_push[AW-1:0];
    head_d       = head_q + {{(AW - 1){1'b0}}, pop};
    count_d      = count_q + n_push - {{AW{1'b0}}, pop};
    overflow_d   = overflow_q || (stall_req && (lane0_ok || lane1_ok));
    commit_cnt_d = commit_cnt_q + {31'd0, pop};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      commit_cnt_q <= '0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      commit_cnt_q <= commit_cnt_d;
    end
  end

  // Storage is not reset; count_q gates every read.
  always_ff @(posedge clk) begin
    if (do_push0) mem_q[tail_q] <= '{pc: wb0_pc, rd: wb0_rd, wdata: wb0_wdata};
    if (do_push1) mem_q[wr1_idx] <= '{pc: wb1_pc, rd: wb1_rd, wdata: wb1_wdata};
  end

  always_comb begin
    debug_wb_pc       = '0;
    debug_wb_rf_wnum  = '0;
    debug_wb_rf_wdata = '0;
    debug_wb_rf_wen   = {4{out_valid}};
    if (out_valid) begin
      debug_wb_pc       = head_entry.pc;
      debug_wb_rf_wnum  = head_entry.rd;
      debug_wb_rf_wdata = head_entry.wdata;
    end
  end

  assign overflow   = overflow_q;
  assign commit_cnt = commit_cnt_q;

endmodule
